// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex scanner for an N-digit common-anode 7-seg display.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark slots for leading zero digits).
module hex_digit_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_en,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              dig_hex,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    dig_blank
);

  localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [3:0]              r_hex;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_blank;

  logic                    w_tick;
  logic                    w_frame_end;
  logic                    w_xfer;
  logic [IW-1:0]           w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_val;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_sel_nxt;
  logic                    w_blank_nxt;

  assign w_tick      = scan_en & (r_presc == LAST_CNT);
  assign w_frame_end = (r_idx == LAST_IDX);
  assign load_ready  = w_tick & w_frame_end;
  assign w_xfer      = load_valid & load_ready;
  assign w_idx_nxt   = w_frame_end ? '0 : r_idx + 1'b1;

  // Digit 0 of a new frame comes straight from load_data so the load costs no latency.
  assign w_val     = w_xfer ? load_data : r_disp;
  assign w_nib     = w_val[{w_idx_nxt, 2'b00} +: 4];
  assign w_sel_nxt = ~(NUM_DIGITS'(1) << w_idx_nxt);

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_upper_zero;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_upz
    assign w_upper_zero[k] = ~|w_val[4*NUM_DIGITS-1:4*k];
  end
  assign w_blank_nxt = (w_idx_nxt != '0) & w_upper_zero[w_idx_nxt];
`else
  assign w_blank_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp  <= '0;
      r_presc <= '0;
      r_idx   <= LAST_IDX;
      r_hex   <= '0;
      r_sel   <= '1;
      r_blank <= 1'b1;
    end else begin
      if (w_xfer) r_disp <= load_data;
      if (scan_en) begin
        if (w_tick) begin
          r_presc <= '0;
          r_idx   <= w_idx_nxt;
          r_hex   <= w_nib;
          r_sel   <= w_blank_nxt ? '1 : w_sel_nxt;
          r_blank <= w_blank_nxt;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end else begin
        // Frozen: counters hold, display goes dark, nibble kept.
        r_sel   <= '1;
        r_blank <= 1'b1;
      end
    end
  end

  assign dig_hex   = r_hex;
  assign dig_sel   = r_sel;
  assign dig_blank = r_blank;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner at NUM_DIGITS=4, REFRESH_DIV=4.
module tb_hex_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  dig_hex;
  logic [3:0]  dig_sel;
  logic        dig_blank;

  int n_tests = 0;
  int n_fail  = 0;

  hex_digit_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .dig_hex(dig_hex), .dig_sel(dig_sel), .dig_blank(dig_blank)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (load_ready !== 1'b1 && cnt < 100) begin
      step(1);
      cnt++;
    end
    n_tests++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ready: load_ready=%b after %0d cycles, required 1", load_ready, cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_en = 1'b0; load_valid = 1'b0; load_data = '0;
    step(2);
    n_tests++;
    if ({dig_sel, dig_blank, dig_hex, load_ready} !== {4'b1111, 1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: sel=%b blank=%b hex=%h ready=%b, required 1111 1 0 0",
               dig_sel, dig_blank, dig_hex, load_ready);
    end
    rst_n = 1'b1; scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (dig_sel !== 4'b1111 || dig_blank !== 1'b1 || load_ready !== (i == 3)) begin
        n_fail++;
        $display("FAIL first_frame c%0d: sel=%b blank=%b ready=%b, required 1111 1 %0d",
                 i, dig_sel, dig_blank, load_ready, (i == 3));
      end
      step(1);
    end
    n_tests++;
    if (dig_sel !== 4'b1110 || dig_hex !== 4'h0 || dig_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL first_digit: sel=%b hex=%h blank=%b, required 1110 0 0",
               dig_sel, dig_hex, dig_blank);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_hex [4];
    logic [3:0] exp_sel [4];
    exp_hex = '{4'hF, 4'hA, 4'h2, 4'h1};
    exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    load_valid = 1'b1; load_data = 16'h12AF;
    wait_ready();
    step(1);
    load_valid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        n_tests++;
        if (dig_hex !== exp_hex[d] || dig_sel !== exp_sel[d] || dig_blank !== 1'b0) begin
          n_fail++;
          $display("FAIL load_scan d%0d c%0d: hex=%h sel=%b blank=%b, required %h %b 0",
                   d, c, dig_hex, dig_sel, dig_blank, exp_hex[d], exp_sel[d]);
        end
        step(1);
      end
    end
  endtask

  task automatic test_one_per_frame();
    int xfers;
    step(4);
    load_valid = 1'b1; load_data = 16'h3456;
    n_tests++;
    if (load_ready !== 1'b0 || dig_hex !== 4'hA) begin
      n_fail++;
      $display("FAIL midframe_ready: ready=%b hex=%h, required 0 a", load_ready, dig_hex);
    end
    step(4);
    n_tests++;
    if (dig_hex !== 4'h2) begin
      n_fail++;
      $display("FAIL old_digit2: hex=%h, required 2", dig_hex);
    end
    step(4);
    n_tests++;
    if (dig_hex !== 4'h1 || dig_sel !== 4'b0111) begin
      n_fail++;
      $display("FAIL old_digit3: hex=%h sel=%b, required 1 0111", dig_hex, dig_sel);
    end
    step(3);
    n_tests++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_ready: ready=%b, required 1", load_ready);
    end
    step(1);
    n_tests++;
    if (dig_hex !== 4'h6 || dig_sel !== 4'b1110) begin
      n_fail++;
      $display("FAIL new_digit0: hex=%h sel=%b, required 6 1110", dig_hex, dig_sel);
    end
    xfers = 0;
    for (int i = 0; i < 32; i++) begin
      if (load_ready === 1'b1 && load_valid === 1'b1) xfers++;
      step(1);
    end
    load_valid = 1'b0;
    n_tests++;
    if (xfers != 2) begin
      n_fail++;
      $display("FAIL xfers_per_frame: got %0d transfers in 2 frames, required 2", xfers);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] exp_sel;
    logic       exp_blank;
    load_valid = 1'b1; load_data = 16'h0005;
    wait_ready();
    step(1);
    load_valid = 1'b0;
    n_tests++;
    if (dig_hex !== 4'h5 || dig_sel !== 4'b1110 || dig_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL lz_digit0: hex=%h sel=%b blank=%b, required 5 1110 0",
               dig_hex, dig_sel, dig_blank);
    end
    for (int d = 1; d < 4; d++) begin
      step(4);
`ifdef LEADING_ZERO_BLANK_EN
      exp_sel = 4'b1111; exp_blank = 1'b1;
`else
      exp_sel = ~(4'b0001 << d); exp_blank = 1'b0;
`endif
      n_tests++;
      if (dig_hex !== 4'h0 || dig_sel !== exp_sel || dig_blank !== exp_blank) begin
        n_fail++;
        $display("FAIL lz_digit%0d: hex=%h sel=%b blank=%b, required 0 %b %b",
                 d, dig_hex, dig_sel, dig_blank, exp_sel, exp_blank);
      end
    end
    step(1);
    load_valid = 1'b1; load_data = 16'h0000;
    wait_ready();
    step(1);
    load_valid = 1'b0;
    n_tests++;
    if (dig_hex !== 4'h0 || dig_sel !== 4'b1110 || dig_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_value: hex=%h sel=%b blank=%b, required 0 1110 0",
               dig_hex, dig_sel, dig_blank);
    end
  endtask

  task automatic test_scan_off();
    load_valid = 1'b1; load_data = 16'h4321;
    wait_ready();
    step(1);
    load_valid = 1'b0;
    step(6);
    n_tests++;
    if (dig_hex !== 4'h2 || dig_sel !== 4'b1101) begin
      n_fail++;
      $display("FAIL pre_freeze: hex=%h sel=%b, required 2 1101", dig_hex, dig_sel);
    end
    scan_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_tests++;
      if (dig_sel !== 4'b1111 || dig_blank !== 1'b1 || load_ready !== 1'b0 || dig_hex !== 4'h2) begin
        n_fail++;
        $display("FAIL frozen c%0d: sel=%b blank=%b ready=%b hex=%h, required 1111 1 0 2",
                 i, dig_sel, dig_blank, load_ready, dig_hex);
      end
    end
    scan_en = 1'b1;
    step(1);
    n_tests++;
    if (dig_sel !== 4'b1111 || dig_blank !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_dark: sel=%b blank=%b, required 1111 1", dig_sel, dig_blank);
    end
    step(1);
    n_tests++;
    if (dig_hex !== 4'h3 || dig_sel !== 4'b1011 || dig_blank !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_next: hex=%h sel=%b blank=%b, required 3 1011 0",
               dig_hex, dig_sel, dig_blank);
    end
  endtask

  task automatic test_async_reset();
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dig_sel, dig_blank, dig_hex, load_ready} !== {4'b1111, 1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: sel=%b blank=%b hex=%h ready=%b, required 1111 1 0 0",
               dig_sel, dig_blank, dig_hex, load_ready);
    end
    step(2);
    rst_n = 1'b1;
    wait_ready();
    step(1);
    n_tests++;
    if (dig_hex !== 4'h0 || dig_sel !== 4'b1110) begin
      n_fail++;
      $display("FAIL post_reset_d0: hex=%h sel=%b, required 0 1110", dig_hex, dig_sel);
    end
    step(4);
    n_tests++;
    if (dig_hex !== 4'h0) begin
      n_fail++;
      $display("FAIL post_reset_d1: hex=%h, required 0", dig_hex);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_one_per_frame();
    test_leading_zero();
    test_scan_off();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
